// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO-attached 8N1 UART transmitter with a small TX FIFO,
// a programmable baud divisor, sticky overflow and a TX-empty interrupt.
// Register map (word offsets): 0x0 TXDATA, 0x4 STATUS, 0x8 CTRL, 0xC BAUDDIV.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wr_data,
    output logic [31:0] bus_rd_data,
    input  logic        bus_cs,
    input  logic        bus_wr,
    input  logic        bus_rd,
    output logic        uart_tx,
    output logic        irq_tx_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic            ovf_reg, ovf_next;
    logic            en_reg, irq_en_reg;
    logic [15:0]     div_reg;
    logic [15:0]     baud_reg, baud_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shifter_reg, shifter_next;
    logic            tx_reg, tx_next;
    logic            irq_reg;

    logic            hit, wr_txdata, wr_ctrl, wr_div;
    logic [1:0]      sel;
    logic            empty, full, pop, push_ok, push_drop, bit_done;
    logic [15:0]     bit_load;
    logic [5:0]      count_ext;
    logic            unused_bits;

    assign hit       = bus_cs && (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign sel       = bus_addr[3:2];
    assign wr_txdata = hit && bus_wr && (sel == 2'd0);
    assign wr_ctrl   = hit && bus_wr && (sel == 2'd2);
    assign wr_div    = hit && bus_wr && (sel == 2'd3);
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(FIFO_DEPTH));
    // A divisor of zero behaves like one: each bit lasts a single clock.
    assign bit_load  = (div_reg == 16'd0) ? 16'd0 : div_reg - 16'd1;
    assign bit_done  = (baud_reg == 16'd0);
    assign count_ext = 6'(count_reg);
    assign unused_bits = ^{bus_addr[1:0], bus_wr_data[31:16]};

    // Next-state for the serialiser: bit timing, shifting and FIFO pops.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shifter_next = shifter_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en_reg && !empty) begin
                    pop          = 1'b1;
                    state_next   = START;
                    baud_next    = bit_load;
                    shifter_next = fifo_mem[rd_ptr_reg];
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    baud_next    = bit_load;
                    bit_idx_next = 3'd0;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_next = bit_load;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shifter_next = {1'b0, shifter_reg[7:1]};
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (en_reg && !empty) begin
                        pop          = 1'b1;
                        state_next   = START;
                        baud_next    = bit_load;
                        shifter_next = fifo_mem[rd_ptr_reg];
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Line level follows the state being entered so uart_tx stays registered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shifter_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // FIFO occupancy and sticky overflow; a pop frees room for a same-cycle push.
    always_comb begin
        push_ok   = wr_txdata && (!full || pop);
        push_drop = wr_txdata && !push_ok;
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        ovf_next = ovf_reg;
        if (wr_ctrl && bus_wr_data[1]) ovf_next = 1'b0;
        if (push_drop)                 ovf_next = 1'b1;
    end

    // State, control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            en_reg      <= 1'b1;
            irq_en_reg  <= 1'b0;
            div_reg     <= DEFAULT_DIV;
            baud_reg    <= 16'd0;
            bit_idx_reg <= 3'd0;
            shifter_reg <= 8'd0;
            tx_reg      <= 1'b1;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shifter_reg <= shifter_next;
            tx_reg      <= tx_next;
            irq_reg     <= irq_en_reg && empty && (state_reg == IDLE);
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (wr_ctrl) begin
                en_reg     <= bus_wr_data[0];
                irq_en_reg <= bus_wr_data[2];
            end
            if (wr_div) div_reg <= bus_wr_data[15:0];
        end
    end

    // FIFO storage; emptied on reset by the pointer/count reset alone.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= bus_wr_data[7:0];
    end

    // Combinational read mux, zero unless this is a load hitting the block.
    always_comb begin
        bus_rd_data = 32'h0;
        if (hit && bus_rd) begin
            case (sel)
                2'd1:    bus_rd_data = {22'h0, count_ext, ovf_reg, empty, full,
                                        (state_reg != IDLE)};
                2'd2:    bus_rd_data = {29'h0, irq_en_reg, 1'b0, en_reg};
                2'd3:    bus_rd_data = {16'h0, div_reg};
                default: bus_rd_data = 32'h0;
            endcase
        end
    end

    assign uart_tx      = tx_reg;
    assign irq_tx_empty = irq_reg;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: drives MMIO stores/loads and decodes the serial line with
// a cycle-exact 8N1 receiver, comparing bytes against a queue of accepted writes.
module tb_mmio_uart_tx;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_CT = 32'h1000_0008;
    localparam logic [31:0] A_BD = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_addr = 32'h0;
    logic [31:0] bus_wr_data = 32'h0;
    logic [31:0] bus_rd_data;
    logic        bus_cs = 1'b0;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic        uart_tx;
    logic        irq_tx_empty;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          cur_div = 434;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    int          mon_d;
    logic [9:0]  mon_fr;
    logic        mon_abort;

    mmio_uart_tx dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .uart_tx(uart_tx), .irq_tx_empty(irq_tx_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wr_data = d;
        @(posedge clk); #1;
        bus_cs = 1'b0; bus_wr = 1'b0;
        $display("WR addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = a;
        #1 d = bus_rd_data;
        @(posedge clk); #1;
        bus_cs = 1'b0; bus_rd = 1'b0;
        $display("RD addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic send(input logic [7:0] b);
        bus_write(A_TX, {24'h0, b});
        exp_q.push_back(b);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Poll STATUS until not busy and empty, then confirm the idle status word.
    task automatic wait_idle(input int budget);
        logic [31:0] s;
        bit ok;
        ok = 0;
        s = 32'h0;
        for (int i = 0; i < budget; i++) begin
            bus_read(A_ST, s);
            if (s[0] == 1'b0 && s[2] == 1'b1) begin ok = 1; break; end
        end
        check("idle_reached", {31'h0, ok}, 32'h1);
        check("status_idle", s, 32'h4);
    endtask

    // Serial receiver: every clock of every bit must carry the expected level.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                mon_d = (cur_div == 0) ? 1 : cur_div;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'h1, 32'h0);
                end else begin
                    mon_fr = {1'b1, exp_q.pop_front(), 1'b0};
                    mon_abort = 1'b0;
                    for (int i = 0; i < 10 && !mon_abort; i++) begin
                        for (int k = 0; k < mon_d && !mon_abort; k++) begin
                            if (i != 0 || k != 0) @(negedge clk);
                            if (!mon_en) mon_abort = 1'b1;
                            else check("tx_bit", {31'h0, uart_tx}, {31'h0, mon_fr[i]});
                        end
                    end
                    if (!mon_abort) $display("RX byte=0x%02h div=%0d", mon_fr[8:1], mon_d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int d, n, k;
        bit ok;

        // Reset state
        repeat (3) @(posedge clk);
        check("tx_in_reset", {31'h0, uart_tx}, 32'h1);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("tx_reset", {31'h0, uart_tx}, 32'h1);
        check("irq_reset", {31'h0, irq_tx_empty}, 32'h0);
        check("rd_idle", bus_rd_data, 32'h0);
        mon_en = 1'b1;
        read_check("status_reset", A_ST, 32'h4);
        read_check("ctrl_reset", A_CT, 32'h1);
        read_check("div_reset", A_BD, 32'd434);
        read_check("txdata_read", A_TX, 32'h0);
        read_check("nonhit_read", 32'h1000_0014, 32'h0);
        read_check("nonhit_read2", 32'h2000_0004, 32'h0);
        bus_cs = 1'b1; bus_addr = A_ST; #1;
        check("cs_no_rd", bus_rd_data, 32'h0);
        bus_cs = 1'b0; bus_rd = 1'b1; #1;
        check("rd_no_cs", bus_rd_data, 32'h0);
        bus_rd = 1'b0;
        @(posedge clk); #1;

        // Single byte with DIV=4, including the two-clock start latency
        bus_write(A_BD, 32'd4); cur_div = 4;
        read_check("div_write", A_BD, 32'd4);
        send(8'h55);
        check("lat_c1_high", {31'h0, uart_tx}, 32'h1);
        read_check("status_queued", A_ST, 32'h10);
        check("lat_c2_low", {31'h0, uart_tx}, 32'h0);
        read_check("status_busy", A_ST, 32'h5);
        wait_idle(100);

        // Back-to-back frames with DIV=2; COUNT goes 2, 1, 0
        bus_write(A_BD, 32'd2); cur_div = 2;
        bus_write(A_CT, 32'h0);
        send(8'hA5);
        send(8'h3C);
        bus_read(A_ST, s);
        check("b2b_count2", {26'h0, s[9:4]}, 32'd2);
        start_q.delete();
        bus_write(A_CT, 32'h1);
        @(posedge clk); #1;
        bus_read(A_ST, s);
        check("b2b_count1", {26'h0, s[9:4]}, 32'd1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            bus_read(A_ST, s);
            if (s[9:4] == 6'd0) begin ok = 1; break; end
        end
        check("b2b_count0", {31'h0, ok}, 32'h1);
        wait_idle(100);
        check("b2b_frames", start_q.size(), 32'd2);
        if (start_q.size() == 2) check("b2b_gap", start_q[1] - start_q[0], 32'd20);

        // Overflow with EN cleared, then clear OVF and re-enable together
        d = $urandom_range(1, 3);
        bus_write(A_BD, d); cur_div = d;
        bus_write(A_CT, 32'h0);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            bus_write(A_TX, {24'h0, b});
            if (i < 8) exp_q.push_back(b);
        end
        read_check("status_ovf", A_ST, 32'h8A);
        bus_write(A_CT, 32'h3);
        bus_read(A_ST, s);
        check("ovf_cleared", {31'h0, s[3]}, 32'h0);
        wait_idle(400);

        // DIV=0 behaves as one clock per bit, raw value reads back
        bus_write(A_BD, 32'd0); cur_div = 0;
        read_check("div_zero", A_BD, 32'd0);
        send(8'hFF);
        wait_idle(50);

        // Randomized bursts at random divisors with random gaps
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(0, 5);
            bus_write(A_BD, d); cur_div = d;
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                send(8'($urandom));
                repeat ($urandom_range(0, 15)) @(posedge clk);
                #1;
            end
            wait_idle(600);
        end

        // Interrupt: drops while busy, rises one cycle after IDLE
        bus_write(A_BD, 32'd3); cur_div = 3;
        bus_write(A_CT, 32'h7);
        read_check("ctrl_w1c_reads0", A_CT, 32'h5);
        @(posedge clk); #1;
        check("irq_idle", {31'h0, irq_tx_empty}, 32'h1);
        send(8'hC3);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            k++;
            if (k == 5) check("irq_busy", {31'h0, irq_tx_empty}, 32'h0);
            if (k > 5 && irq_tx_empty) break;
        end
        check("irq_rise_cycle", k, 32'd32);

        // Reset in the middle of the data bits
        bus_write(A_BD, 32'd8); cur_div = 8;
        send(8'h81);
        repeat (30) @(posedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1 check("tx_async_reset", {31'h0, uart_tx}, 32'h1);
        check("irq_async_reset", {31'h0, irq_tx_empty}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        cur_div = 434;
        read_check("status_after_reset", A_ST, 32'h4);
        read_check("ctrl_after_reset", A_CT, 32'h1);
        read_check("div_after_reset", A_BD, 32'd434);
        repeat (5) @(posedge clk); #1;
        check("tx_idle_after_reset", {31'h0, uart_tx}, 32'h1);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
